// File: rtl/median9_seq.sv
// -----------------------------------------------------------------------------
// median9_seq
//
// Sequential median-of-9 engine. A single W-bit compare-exchange unit is
// time-shared across the 19 steps of the Paeth median network. The step
// order comes from a small ROM and the working set lives in a 9-entry
// register file. One compare-exchange executes per clock. Latency does not
// depend on the data.
//
// Parameters
//   W       unsigned element width (W >= 1)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   start   job request, sampled only while idle
//   din     nine elements, element i = din[W*i +: W]
//   busy    high while a job is in flight
//   done    registered one-cycle pulse, median valid
//   median  registered result, held until the next done
//
// Timing: if edge k samples start in IDLE, edges k+1..k+19 execute steps
// 0..18, edge k+20 enters FIN and edge k+21 loads median and raises done.
// A new job can be accepted at edge k+22, giving a 22-cycle period.
// -----------------------------------------------------------------------------
module median9_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [9*W-1:0] din,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   median
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd18;

    state_t         state_q, state_d;
    logic [4:0]     step_q,  step_d;
    logic [W-1:0]   r_q [9];
    logic [W-1:0]   r_d [9];
    logic [W-1:0]   median_q, median_d;
    logic           done_q,   done_d;

    // Operand selection for the current step.
    logic [3:0]     idx_a, idx_b;
    logic [W-1:0]   a_val, b_val;
    logic           do_swap;

    // -------------------------------------------------------------------------
    // Schedule ROM: 19 index pairs of the Paeth median network. After the
    // last pair, r[4] holds the median; the other entries are not sorted.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        idx_a = 4'd0;
        idx_b = 4'd0;
        case (step_q)
            5'd0:  begin idx_a = 4'd1; idx_b = 4'd2; end
            5'd1:  begin idx_a = 4'd4; idx_b = 4'd5; end
            5'd2:  begin idx_a = 4'd7; idx_b = 4'd8; end
            5'd3:  begin idx_a = 4'd0; idx_b = 4'd1; end
            5'd4:  begin idx_a = 4'd3; idx_b = 4'd4; end
            5'd5:  begin idx_a = 4'd6; idx_b = 4'd7; end
            5'd6:  begin idx_a = 4'd1; idx_b = 4'd2; end
            5'd7:  begin idx_a = 4'd4; idx_b = 4'd5; end
            5'd8:  begin idx_a = 4'd7; idx_b = 4'd8; end
            5'd9:  begin idx_a = 4'd0; idx_b = 4'd3; end
            5'd10: begin idx_a = 4'd5; idx_b = 4'd8; end
            5'd11: begin idx_a = 4'd4; idx_b = 4'd7; end
            5'd12: begin idx_a = 4'd3; idx_b = 4'd6; end
            5'd13: begin idx_a = 4'd1; idx_b = 4'd4; end
            5'd14: begin idx_a = 4'd2; idx_b = 4'd5; end
            5'd15: begin idx_a = 4'd4; idx_b = 4'd7; end
            5'd16: begin idx_a = 4'd4; idx_b = 4'd2; end
            5'd17: begin idx_a = 4'd6; idx_b = 4'd4; end
            5'd18: begin idx_a = 4'd4; idx_b = 4'd2; end
            default: begin idx_a = 4'd0; idx_b = 4'd0; end
        endcase
    end

    // The single shared comparator. Equal values never swap.
    assign a_val   = r_q[idx_a];
    assign b_val   = r_q[idx_b];
    assign do_swap = (a_val > b_val);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        median_d = median_q;
        done_d   = 1'b0;
        r_d      = r_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 9; i++) begin
                        r_d[i] = din[W*i +: W];
                    end
                    step_d  = 5'd0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (step_q <= LAST_STEP) begin
                    if (do_swap) begin
                        r_d[idx_a] = b_val;
                        r_d[idx_b] = a_val;
                    end
                    step_d = step_q + 5'd1;
                end else begin
                    // One idle cycle after the final compare-exchange keeps
                    // the fixed 22-cycle job period.
                    state_d = FIN;
                end
            end

            FIN: begin
                median_d = r_q[4];
                done_d   = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= 5'd0;
            median_q <= '0;
            done_q   <= 1'b0;
            // NOTE: the register file is cleared on reset so that an aborted
            // job leaves no stale data behind; it is small enough that the
            // reset fan-out is harmless.
            for (int i = 0; i < 9; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q  <= state_d;
            step_q   <= step_d;
            median_q <= median_d;
            done_q   <= done_d;
            for (int i = 0; i < 9; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign median = median_q;

endmodule

// File: tb/tb_median9_seq.sv
// -----------------------------------------------------------------------------
// tb_median9_seq
//
// Directed vector table for median9_seq (W = 8), followed by sequences for
// back-to-back jobs, mid-run reset and a random regression against a
// software sort.
// -----------------------------------------------------------------------------
module tb_median9_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [9*W-1:0] din;
    logic           busy;
    logic           done;
    logic [W-1:0]   median;

    int n_cmp = 0;
    int n_bad = 0;

    median9_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .median (median)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] din;
        logic [7:0]  exp;
        bit          probe_rf;
        string       name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk9(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3,
                                        input logic [7:0] a4, input logic [7:0] a5,
                                        input logic [7:0] a6, input logic [7:0] a7,
                                        input logic [7:0] a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    // Reference: fifth smallest of nine, by insertion sort.
    function automatic logic [7:0] median_ref(input logic [71:0] d);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = d[8*i +: 8];
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t = a[j-1]; a[j-1] = a[j]; a[j] = t;
                end
            end
        end
        return a[4];
    endfunction

    // Runs one job starting at posedge+1; returns at posedge+1 one cycle
    // after done. din is scrambled once the job is accepted.
    task automatic run_job(input logic [71:0] d, input logic [7:0] exp, input string name);
        int n;
        bit seen;
        start = 1'b1;
        din   = d;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rnd72();
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            din = rnd72();
            if (n == 20) check({name, " busy_at_k20"}, 32'(busy), 32'd1);
            if (done) seen = 1'b1;
        end
        check({name, " done_latency"}, 32'(n), 32'd21);
        check({name, " median"}, 32'(median), 32'(exp));
        check({name, " busy_low_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        check({name, " median_held"}, 32'(median), 32'(exp));
    endtask

    initial begin
        logic [71:0] jobs [3];
        logic [7:0]  jexp [3];
        int          j;
        int          dones;
        logic [71:0] d;

        vecs[0] = '{mk9(8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4), 8'd5, 1'b0, "ramp_mix"};
        vecs[1] = '{{9{8'hAA}}, 8'hAA, 1'b1, "all_aa"};
        vecs[2] = '{mk9(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80), 8'h80, 1'b0, "extremes"};
        vecs[3] = '{mk9(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 8'd4, 1'b0, "ascending"};
        vecs[4] = '{mk9(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0), 8'd4, 1'b0, "descending"};
        vecs[5] = '{mk9(8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9), 8'd5, 1'b0, "triplets"};
        vecs[6] = '{mk9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1), 8'd0, 1'b0, "one_high"};
        vecs[7] = '{mk9(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00), 8'hFF, 1'b0, "one_low"};

        // Reset values.
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset median", 32'(median), 32'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].din, vecs[i].exp, vecs[i].name);
            if (vecs[i].probe_rf) begin
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("%s rf[%0d]", vecs[i].name, k), 32'(dut.r_q[k]), 32'(vecs[i].exp));
                end
            end
        end

        // Back-to-back: start held high, din changes every cycle.
        jobs[0] = mk9(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90);
        jobs[1] = mk9(8'd200, 8'd1, 8'd150, 8'd3, 8'd100, 8'd7, 8'd90, 8'd2, 8'd250);
        jobs[2] = mk9(8'd4, 8'd4, 8'd8, 8'd8, 8'd6, 8'd6, 8'd2, 8'd2, 8'd5);
        jexp[0] = 8'd50;
        jexp[1] = 8'd90;
        jexp[2] = 8'd5;
        j = 0;
        for (int c = 0; c < 66; c++) begin
            start = 1'b1;
            din   = (c % 22 == 0) ? jobs[c / 22] : rnd72();
            @(posedge clk); #1;
            if (done) begin
                if (j < 3) begin
                    check($sformatf("b2b job%0d edge", j), 32'(c), 32'(22 * j + 21));
                    check($sformatf("b2b job%0d median", j), 32'(median), 32'(jexp[j]));
                end
                j++;
            end
            if (c % 22 == 21) check($sformatf("b2b busy_low c%0d", c), 32'(busy), 32'd0);
        end
        start = 1'b0;
        check("b2b job count", 32'(j), 32'd3);
        @(posedge clk); #1;
        check("b2b idle after release", 32'(busy), 32'd0);

        // Establish a nonzero held median, then reset mid-run at step 10.
        run_job(vecs[0].din, vecs[0].exp, "pre_reset");
        start = 1'b1;
        din   = vecs[3].din;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort at step10", 32'(dut.step_q), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort median", 32'(median), 32'd0);
        #2 rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no done after abort", 32'(dones), 32'd0);
        run_job(vecs[5].din, vecs[5].exp, "post_reset");

        // Random regression.
        for (int n = 0; n < 1000; n++) begin
            d = rnd72();
            run_job(d, median_ref(d), $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median9_seq.md
# median9_seq

Sequential median-of-9 engine that time-shares one W-bit compare-exchange unit across the 19-step Paeth median network. It replaces a fully unrolled comparator tree with a schedule ROM, a 9-entry register file and a small FSM. It sits beside the combinational min/max networks as their area-reduced, sequenced counterpart. One compare-exchange executes per clock.

## Interface
- W, default 8, unsigned element width (W ≥ 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- din  input  9*W  nine elements; element i = din[W*i +: W]
- busy  output  1  high while state ≠ IDLE
- done  output  1  registered one-cycle pulse; median valid
- median  output  W  registered result, held until next done

## Operation
- Registers: r[0..8] (W bits each), step (5 bits), state, median, done.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 → r[i] ← din element i, step ← 0, state ← RUN.
  - start=0 → hold all registers.
- RUN:
  - Executes op(a,b) = schedule[step], then step ← step+1.
  - op(a,b): if r[a] > r[b] (unsigned), swap them so r[a] = min and r[b] = max.
  - Equal values: no swap.
  - After step 18 executes, state ← FIN.
- FIN: median ← r[4], done ← 1, state ← IDLE.
- done ← 0 in every state other than FIN.
- Schedule, steps 0..18: (1,2) (4,5) (7,8) (0,1) (3,4) (6,7) (1,2) (4,5) (7,8) (0,3) (5,8) (4,7) (3,6) (1,4) (2,5) (4,7) (4,2) (6,4) (4,2).
- Only r[4] is defined as the median; other r[] contents after the run are don't-care.
- start in RUN or FIN: ignored, no queuing. din is don't-care outside the IDLE start cycle.
- Comparator, mux and swap logic exist once. The schedule is a 19-entry ROM of 4-bit index pairs.
- Reset (asynchronous, any state, including mid-run): state ← IDLE, step ← 0, r[] ← 0, median ← 0, done ← 0. The in-flight job is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, median=0.
- Let edge k sample start=1 in IDLE.
  - Edges k+1..k+19 execute steps 0..18.
  - Edge k+20 enters FIN.
  - Edge k+21 loads median and sets done.
- busy is high from after edge k through edge k+20, and low after edge k+21.
- done is high for exactly the cycle after edge k+21.
- Earliest next start is sampled at edge k+22, when done is high and state is IDLE. Back-to-back period is 22 cycles.
- median is stable between done pulses.
- Latency is independent of data. No early termination.

## Test plan
- Load din = {9,3,7,1,5,8,2,6,4} (element 0 = 9) with start pulsed at edge k → median=5, done high only after edge k+21, busy low afterward.
- All elements 0xAA → median=0xAA. Register-file probe shows no swaps performed.
- Extremes: elements {0xFF,0x00,0xFF,0x00,0xFF,0x00,0xFF,0x00,0x80} → median=0x80. Confirms unsigned compare.
- Hold start=1 continuously with changing din → one job per 22 cycles. Each median matches the din captured at its IDLE sample. Mid-run din changes have no effect.
- Assert rst at step 10 of a run → busy=0, done=0, median=0 immediately. No done follows. A fresh start then completes normally.
- Random regression: 1000 jobs with random W=8 data → median equals the 5th smallest value from a software sort, every job.
